// File: rtl/vadd_i8v4_arbiter_pkg.sv
// Shared definitions for the i8v4 adder scheduler.
//   LANES/LANE_W/VEC_W : vector geometry (4 lanes of 8 bits)
//   IDX_W              : requester index width (covers up to 4 requesters)
//   tag_t              : in-flight tag, a valid bit plus the originating requester
package vadd_i8v4_arbiter_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;
   localparam int VEC_W  = LANES * LANE_W;
   localparam int IDX_W  = 2;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/vadd_i8v4_arbiter_rr_arbiter.sv
// Pointer-based round-robin arbiter.
//   clock, reset : clock, synchronous active-high reset
//   req_valid    : NREQ request lines
//   grant        : one-hot grant, first valid requester at or after the pointer
//   grant_idx    : binary index of the granted requester (meaningful when |grant)
// Every grant is a transfer (only valid requesters are granted), so the pointer
// advances past the winner whenever any grant is issued.
module vadd_i8v4_arbiter_rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        grant,
   output logic [$clog2(NREQ)-1:0] grant_idx
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int SUM_W = PTR_W + 1;

   logic [PTR_W-1:0] ptr;
   logic [SUM_W-1:0] cand_sum;
   logic [PTR_W-1:0] cand;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand_sum  = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         // Modulo-NREQ walk starting at the pointer; NREQ need not be a power of two.
         cand_sum = {1'b0, ptr} + SUM_W'(k);
         if (cand_sum >= SUM_W'(NREQ)) begin
            cand_sum = cand_sum - SUM_W'(NREQ);
         end
         cand = cand_sum[PTR_W-1:0];
         if (!found && req_valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
      // No transfers are accepted while reset is held.
      if (reset) begin
         grant = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (|grant) begin
         ptr <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end

endmodule

// File: rtl/vadd_i8v4_arbiter.sv
// Round-robin scheduler sharing one i8v4 lane-wise adder among NREQ requesters.
//   clock, reset : clock, synchronous active-high reset
//   req_valid    : requester i has an operand pair
//   req_ready    : one-hot grant; transfer on req_valid[i] & req_ready[i]
//   req_a, req_b : requester operands, requester i at [32i+31:32i]
//   add_a, add_b : registered operands to the adder (hold last issue when idle)
//   add_y        : adder result, LAT cycles after add_a/add_b
//   rsp_valid    : one-hot single-cycle pulse naming the result's requester
//   rsp_y        : result lanes, valid with rsp_valid
//   busy         : any tag in flight
// Total request-to-response latency is 1+LAT cycles with one issue per cycle.
// Responses have no backpressure.
module vadd_i8v4_arbiter
   import vadd_i8v4_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*VEC_W-1:0] req_a,
   input  logic [NREQ*VEC_W-1:0] req_b,
   output logic [VEC_W-1:0]      add_a,
   output logic [VEC_W-1:0]      add_b,
   input  logic [VEC_W-1:0]      add_y,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [VEC_W-1:0]      rsp_y,
   output logic                  busy
);

   localparam int PTR_W = $clog2(NREQ);

   logic [NREQ-1:0]  grant;
   logic [PTR_W-1:0] grant_idx;
   logic [VEC_W-1:0] sel_a;
   logic [VEC_W-1:0] sel_b;
   logic [VEC_W-1:0] add_a_p0;
   logic [VEC_W-1:0] add_b_p0;
   tag_t             tag_p [LAT+1];

   vadd_i8v4_arbiter_rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;

   // One-hot operand select: OR of the granted slice.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a = sel_a | req_a[i*VEC_W +: VEC_W];
            sel_b = sel_b | req_b[i*VEC_W +: VEC_W];
         end
      end
   end

   // ---- issue stage (p0): operands to adder, tag enters delay line ----
   always_ff @(posedge clock) begin
      if (reset) begin
         add_a_p0 <= '0;
         add_b_p0 <= '0;
      end else if (|grant) begin
         add_a_p0 <= sel_a;
         add_b_p0 <= sel_b;
      end
   end

   assign add_a = add_a_p0;
   assign add_b = add_b_p0;

   // ---- tag delay line: stage k holds the tag issued k+1 cycles ago ----
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k <= LAT; k++) begin
            tag_p[k] <= '0;
         end
      end else begin
         tag_p[0].vld <= |grant;
         tag_p[0].idx <= IDX_W'(grant_idx);
         for (int k = 1; k <= LAT; k++) begin
            tag_p[k] <= tag_p[k-1];
         end
      end
   end

   // ---- response: last tag stage lines up with add_y ----
   always_comb begin
      rsp_valid = '0;
      if (!reset && tag_p[LAT].vld) begin
         for (int i = 0; i < NREQ; i++) begin
            if (tag_p[LAT].idx == IDX_W'(i)) begin
               rsp_valid[i] = 1'b1;
            end
         end
      end
   end

   assign rsp_y = add_y;

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         busy = busy | tag_p[k].vld;
      end
   end

endmodule

// File: tb/tb_vadd_i8v4_arbiter.sv
// Bench for vadd_i8v4_arbiter (NREQ=2, LAT=2) with a behavioural adder and a
// cycle-indexed reference model of round-robin grants and response timing.
module tb_vadd_i8v4_arbiter;

   localparam int NREQ = 2;
   localparam int LAT  = 2;
   localparam int MAXC = 1200;

   logic              clock;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [31:0]       add_a;
   logic [31:0]       add_b;
   logic [31:0]       add_y;
   logic [NREQ-1:0]   rsp_valid;
   logic [31:0]       rsp_y;
   logic              busy;

   vadd_i8v4_arbiter #(
      .NREQ (NREQ),
      .LAT  (LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_y     (add_y),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural adder: bytewise add, LAT register stages.
   logic [31:0] ypipe [LAT];
   logic [31:0] ysum;
   always_comb begin
      ysum = '0;
      for (int k = 0; k < 4; k++) ysum[k*8 +: 8] = add_a[k*8 +: 8] + add_b[k*8 +: 8];
   end
   always @(posedge clock) begin
      ypipe[0] <= ysum;
      for (int k = 1; k < LAT; k++) ypipe[k] <= ypipe[k-1];
   end
   assign add_y = ypipe[LAT-1];

   // Reference model state
   int              n_vec = 0;
   int              n_err = 0;
   int              cyc   = 0;
   int              mptr  = 0;
   bit              issued [MAXC];
   bit [NREQ-1:0]   exp_rv [MAXC];
   bit [31:0]       exp_y  [MAXC];
   bit [31:0]       m_add_a = '0;
   bit [31:0]       m_add_b = '0;
   int              lit_cyc = -1;
   bit [31:0]       lit_y;
   bit [NREQ-1:0]   lit_rv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Lane sums written as integer arithmetic mod 256.
   function automatic bit [31:0] lane_sum(input bit [31:0] a, input bit [31:0] b);
      bit [31:0] r;
      int        s;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         s = (int'(a[k*8 +: 8]) + int'(b[k*8 +: 8])) % 256;
         r[k*8 +: 8] = 8'(s);
      end
      return r;
   endfunction

   task automatic step(input bit [NREQ-1:0] v, input bit [31:0] a0, input bit [31:0] b0,
                       input bit [31:0] a1, input bit [31:0] b1, input bit rst);
      int            gi;
      bit [NREQ-1:0] exp_ready;
      bit            busy_exp;
      bit [31:0]     ga;
      bit [31:0]     gb;
      reset     = rst;
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      @(negedge clock);
      gi = -1;
      if (!rst) begin
         for (int k = 0; k < NREQ; k++) begin
            if (gi < 0 && v[(mptr + k) % NREQ]) gi = (mptr + k) % NREQ;
         end
      end
      exp_ready = '0;
      if (gi >= 0) exp_ready[gi] = 1'b1;
      busy_exp = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         if (cyc - 1 - k >= 0 && issued[cyc-1-k]) busy_exp = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), rst ? 32'd0 : 32'(exp_rv[cyc]));
      if (!rst && exp_rv[cyc] != '0) check("rsp_y", rsp_y, exp_y[cyc]);
      check("busy", 32'(busy), 32'(busy_exp));
      check("add_a", add_a, m_add_a);
      check("add_b", add_b, m_add_b);
      if (cyc == lit_cyc) begin
         check("lit_rsp_valid", 32'(rsp_valid), 32'(lit_rv));
         check("lit_rsp_y", rsp_y, lit_y);
      end
      if (rst) begin
         for (int k = 1; k <= LAT; k++) exp_rv[cyc+k] = '0;
         for (int k = 0; k <= LAT; k++) if (cyc - 1 - k >= 0) issued[cyc-1-k] = 1'b0;
         m_add_a = '0;
         m_add_b = '0;
         mptr    = 0;
      end else if (gi >= 0) begin
         ga = (gi == 0) ? a0 : a1;
         gb = (gi == 0) ? b0 : b1;
         issued[cyc] = 1'b1;
         exp_rv[cyc+1+LAT] = '0;
         exp_rv[cyc+1+LAT][gi] = 1'b1;
         exp_y[cyc+1+LAT] = lane_sum(ga, gb);
         m_add_a = ga;
         m_add_b = gb;
         mptr = (gi + 1) % NREQ;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, $urandom, $urandom, $urandom, $urandom, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (2) @(posedge clock);
      #1;
      step('0, 0, 0, 0, 0, 1'b1);

      // Single request on requester 0
      lit_cyc = cyc + 1 + LAT; lit_y = 32'h020205FD; lit_rv = 2'b01;
      step(2'b01, 32'h010202FC, 32'h01000301, $urandom, $urandom, 1'b0);
      idle(4);

      // Lane wrap-around, no inter-lane carry
      lit_cyc = cyc + 1 + LAT; lit_y = 32'h00800100; lit_rv = 2'b01;
      step(2'b01, 32'hFF7F0080, 32'h01010180, $urandom, $urandom, 1'b0);
      idle(4);

      // Both requesters valid: alternating grants, back-to-back responses
      for (int i = 0; i < 8; i++) step(2'b11, $urandom, $urandom, $urandom, $urandom, 1'b0);
      idle(4);

      // Requester 1 alone, then both: requester 0 wins next
      step(2'b10, $urandom, $urandom, $urandom, $urandom, 1'b0);
      step(2'b11, $urandom, $urandom, $urandom, $urandom, 1'b0);
      step(2'b11, $urandom, $urandom, $urandom, $urandom, 1'b0);
      idle(4);

      // Reset with two tags in flight
      step(2'b11, $urandom, $urandom, $urandom, $urandom, 1'b0);
      step(2'b11, $urandom, $urandom, $urandom, $urandom, 1'b0);
      step(2'b11, $urandom, $urandom, $urandom, $urandom, 1'b1);
      idle(5);

      // Long idle
      idle(10);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(NREQ'($urandom), $urandom, $urandom, $urandom, $urandom,
              ($urandom_range(0, 49) == 0));
      end
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
